// File: rtl/image_sensor_link_sequencer_if.sv
// Signal bundle between the link sequencer and the 8-lane GTH receiver wrapper.
// The sequencer uses the master view. The transceiver/status side uses the slave view.
interface image_sensor_link_sequencer_if #(
  parameter int NUM_LANES = 8
);
  logic                 restart_i;
  logic [NUM_LANES-1:0] gtpowergood_i;
  logic [NUM_LANES-1:0] rxpmaresetdone_i;
  logic                 userclk_rx_active_i;
  logic [NUM_LANES-1:0] rxbyteisaligned_i;
  logic [NUM_LANES-1:0] rxchanisaligned_i;
  logic                 gtwiz_reset_all_o;
  logic                 gtwiz_reset_rx_dp_o;
  logic                 link_up_o;
  logic                 fail_o;
  logic [2:0]           state_o;
  logic [2:0]           retry_cnt_o;
  logic [15:0]          loss_cnt_o;

  modport master (
    input  restart_i, gtpowergood_i, rxpmaresetdone_i, userclk_rx_active_i,
           rxbyteisaligned_i, rxchanisaligned_i,
    output gtwiz_reset_all_o, gtwiz_reset_rx_dp_o, link_up_o, fail_o,
           state_o, retry_cnt_o, loss_cnt_o
  );

  modport slave (
    output restart_i, gtpowergood_i, rxpmaresetdone_i, userclk_rx_active_i,
           rxbyteisaligned_i, rxchanisaligned_i,
    input  gtwiz_reset_all_o, gtwiz_reset_rx_dp_o, link_up_o, fail_o,
           state_o, retry_cnt_o, loss_cnt_o
  );
endinterface

// File: rtl/image_sensor_link_sequencer.sv
// Bring-up and recovery sequencer for the multi-lane image-sensor GTH receiver.
// It pulses the wizard resets, waits for PLL, alignment and bonding, and then holds link_up.
module image_sensor_link_sequencer #(
  parameter int NUM_LANES     = 8,
  parameter int RST_PULSE_CYC = 16,
  parameter int TIMEOUT_CYC   = 1000000,
  parameter int STABLE_CYC    = 1024,
  parameter int GLITCH_CYC    = 8,
  parameter int MAX_RETRY     = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  image_sensor_link_sequencer_if.master link
);

  typedef enum logic [2:0] {
    RESET_ALL  = 3'd0,
    WAIT_PLL   = 3'd1,
    WAIT_ALIGN = 3'd2,
    WAIT_BOND  = 3'd3,
    LINK_UP    = 3'd4,
    RESET_DP   = 3'd5,
    FAILED     = 3'd6
  } state_e;

  localparam int TMR_MAX  = (TIMEOUT_CYC > RST_PULSE_CYC) ? TIMEOUT_CYC : RST_PULSE_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX);
  localparam int STAB_MAX = (STABLE_CYC > GLITCH_CYC) ? STABLE_CYC : GLITCH_CYC;
  localparam int STAB_W   = $clog2(STAB_MAX + 1);
  localparam int SW       = 4 * NUM_LANES + 1;

  localparam logic [TMR_W-1:0]  TMO_LAST    = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  PULSE_LAST  = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [STAB_W-1:0] STABLE_LAST = STAB_W'(STABLE_CYC - 1);
  localparam logic [STAB_W-1:0] GLITCH_LAST = STAB_W'(GLITCH_CYC - 1);
  localparam logic [2:0]        RETRY_LAST  = 3'(MAX_RETRY - 1);

  // Two-flop synchroniser for every status bit. These bits come from async or RXUSRCLK2 sources.
  logic [SW-1:0]        sync_meta, sync_q;
  logic [NUM_LANES-1:0] pg_s, pma_s, ba_s, ca_s;
  logic                 ua_s;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      // NOTE: non-blocking so both stages sample pre-edge values and form a real two-flop chain.
      sync_meta <= {link.gtpowergood_i, link.rxpmaresetdone_i, link.userclk_rx_active_i,
                    link.rxbyteisaligned_i, link.rxchanisaligned_i};
      sync_q    <= sync_meta;
    end
  end

  assign {pg_s, pma_s, ua_s, ba_s, ca_s} = sync_q;

  logic pll_ok, byte_ok, bond_ok;
  assign pll_ok  = (&pg_s) & (&pma_s) & ua_s;
  assign byte_ok = &ba_s;
  assign bond_ok = byte_ok & (&ca_s);

  state_e              state, state_nxt, retry_tgt;
  logic [TMR_W-1:0]    tmr, tmr_nxt;
  logic [STAB_W-1:0]   stab, stab_nxt;
  logic [2:0]          retry_cnt, retry_nxt;
  logic [15:0]         loss_cnt, loss_nxt;
  logic                timed_out, take_retry, pll_lost, count_loss;
  logic                reset_all_q, reset_dp_q, link_up_q, fail_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    retry_tgt  = state;
    take_retry = 1'b0;
    count_loss = 1'b0;
    stab_nxt   = '0;
    retry_nxt  = retry_cnt;
    timed_out  = (tmr == TMO_LAST);
    pll_lost   = !pll_ok && (state inside {WAIT_ALIGN, WAIT_BOND, LINK_UP, RESET_DP});

    if (link.restart_i) begin
      state_nxt = RESET_ALL;
      retry_nxt = '0;
    end else if (pll_lost) begin
      // A PLL loss outranks any alignment loss in the same cycle and does not count as a retry.
      state_nxt  = RESET_ALL;
      count_loss = (state == LINK_UP);
    end else begin
      unique case (state)
        RESET_ALL:  if (tmr == PULSE_LAST) state_nxt = WAIT_PLL;
        WAIT_PLL: begin
          if (pll_ok)          state_nxt = WAIT_ALIGN;
          else if (timed_out) begin take_retry = 1'b1; retry_tgt = RESET_ALL; end
        end
        WAIT_ALIGN: begin
          if (byte_ok)         state_nxt = WAIT_BOND;
          else if (timed_out) begin take_retry = 1'b1; retry_tgt = RESET_DP; end
        end
        WAIT_BOND: begin
          if (bond_ok && stab == STABLE_LAST) begin
            state_nxt = LINK_UP;
            retry_nxt = '0;
          end else if (timed_out) begin
            take_retry = 1'b1;
            retry_tgt  = RESET_DP;
          end else if (bond_ok) begin
            stab_nxt = stab + 1'b1;
          end
        end
        LINK_UP: begin
          if (!bond_ok) begin
            if (stab == GLITCH_LAST) begin
              state_nxt  = RESET_DP;
              count_loss = 1'b1;
            end else begin
              stab_nxt = stab + 1'b1;
            end
          end
        end
        RESET_DP:   if (tmr == PULSE_LAST) state_nxt = WAIT_ALIGN;
        FAILED:     state_nxt = FAILED;
        default:    state_nxt = RESET_ALL;
      endcase

      if (take_retry) begin
        if (retry_cnt == RETRY_LAST) begin
          state_nxt = FAILED;
        end else begin
          state_nxt = retry_tgt;
          retry_nxt = retry_cnt + 1'b1;
        end
      end
    end

    loss_nxt = (count_loss && loss_cnt != '1) ? loss_cnt + 1'b1 : loss_cnt;
    // A restart inside RESET_ALL starts the pulse count again, although the state stays the same.
    tmr_nxt  = (link.restart_i || state_nxt != state) ? '0 : tmr + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= RESET_ALL;
      tmr         <= '0;
      stab        <= '0;
      retry_cnt   <= '0;
      loss_cnt    <= '0;
      reset_all_q <= 1'b1;
      reset_dp_q  <= 1'b0;
      link_up_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmr         <= tmr_nxt;
      stab        <= stab_nxt;
      retry_cnt   <= retry_nxt;
      loss_cnt    <= loss_nxt;
      reset_all_q <= (state_nxt == RESET_ALL);
      reset_dp_q  <= (state_nxt == RESET_DP);
      link_up_q   <= (state_nxt == LINK_UP);
      fail_q      <= (state_nxt == FAILED);
    end
  end

  assign link.gtwiz_reset_all_o   = reset_all_q;
  assign link.gtwiz_reset_rx_dp_o = reset_dp_q;
  assign link.link_up_o           = link_up_q;
  assign link.fail_o              = fail_q;
  assign link.state_o             = state;
  assign link.retry_cnt_o         = retry_cnt;
  assign link.loss_cnt_o          = loss_cnt;

endmodule

// File: tb/tb_image_sensor_link_sequencer.sv
// Randomised bench for image_sensor_link_sequencer. It compares the outputs every cycle
// against a timestamp-based model of the sequencing rules, and adds directed boundary checks.
module tb_image_sensor_link_sequencer;
  localparam int NL     = 8;
  localparam int PULSE  = 8;
  localparam int TMO    = 200;
  localparam int STABLE = 20;
  localparam int GLITCH = 4;
  localparam int MAXR   = 3;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b1;
  always #5 clk_i = ~clk_i;

  image_sensor_link_sequencer_if #(.NUM_LANES(NL)) link ();

  image_sensor_link_sequencer #(
    .NUM_LANES(NL), .RST_PULSE_CYC(PULSE), .TIMEOUT_CYC(TMO),
    .STABLE_CYC(STABLE), .GLITCH_CYC(GLITCH), .MAX_RETRY(MAXR)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .link     (link)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Time in a state is the current cycle minus the cycle the state was
  // entered. The stable and glitch conditions are runs of consecutive good or bad bond cycles.
  typedef struct packed {
    logic [NL-1:0] pg, pma, ba, ca;
    logic          ua;
  } status_t;

  status_t dly0, dly1;
  int m_state, m_retry, m_loss, m_entry, m_cyc, good_run, bad_run;

  task automatic model_reset();
    dly0 = '0; dly1 = '0;
    m_state = 0; m_retry = 0; m_loss = 0;
    m_entry = 0; m_cyc = 0; good_run = 0; bad_run = 0;
  endtask

  function automatic int retry_to(input int target);
    if (m_retry + 1 == MAXR) return 6;
    m_retry++;
    return target;
  endfunction

  task automatic model_edge();
    status_t seen;
    bit      pll, byte_ok, bond, reenter;
    int      tin, nxt;
    seen    = dly1;
    dly1    = dly0;
    dly0    = '{pg: link.gtpowergood_i, pma: link.rxpmaresetdone_i, ba: link.rxbyteisaligned_i,
                ca: link.rxchanisaligned_i, ua: link.userclk_rx_active_i};
    pll     = (&seen.pg) && (&seen.pma) && seen.ua;
    byte_ok = &seen.ba;
    bond    = byte_ok && (&seen.ca);
    good_run = bond ? good_run + 1 : 0;
    bad_run  = bond ? 0 : bad_run + 1;
    tin     = m_cyc - m_entry;
    nxt     = m_state;
    reenter = 1'b0;
    if (link.restart_i) begin
      nxt = 0; m_retry = 0; reenter = 1'b1;
    end else if (!pll && m_state >= 2 && m_state <= 5) begin
      if (m_state == 4 && m_loss < 65535) m_loss++;
      nxt = 0;
    end else begin
      case (m_state)
        0: if (tin == PULSE - 1) nxt = 1;
        1: if (pll) nxt = 2; else if (tin == TMO - 1) nxt = retry_to(0);
        2: if (byte_ok) nxt = 3; else if (tin == TMO - 1) nxt = retry_to(5);
        3: begin
          if (bond && ((good_run < tin + 1) ? good_run : tin + 1) >= STABLE) begin
            nxt = 4; m_retry = 0;
          end else if (tin == TMO - 1) nxt = retry_to(5);
        end
        4: begin
          if (!bond && ((bad_run < tin + 1) ? bad_run : tin + 1) >= GLITCH) begin
            if (m_loss < 65535) m_loss++;
            nxt = 5;
          end
        end
        5: if (tin == PULSE - 1) nxt = 2;
        default: nxt = m_state;
      endcase
    end
    if (reenter || nxt != m_state) m_entry = m_cyc + 1;
    m_state = nxt;
    m_cyc++;
  endtask

  task automatic compare_outs(input string tag);
    logic [31:0] got, exp;
    got = {6'd0, link.state_o, link.gtwiz_reset_all_o, link.gtwiz_reset_rx_dp_o,
           link.link_up_o, link.fail_o, link.retry_cnt_o, link.loss_cnt_o};
    exp = {6'd0, 3'(m_state), m_state == 0, m_state == 5, m_state == 4, m_state == 6,
           3'(m_retry), 16'(m_loss)};
    check(tag, got, exp);
  endtask

  logic [31:0] seq;
  logic [2:0]  last_state;

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    compare_outs("outs");
    if (link.state_o != last_state) begin
      seq        = {seq[27:0], 1'b0, link.state_o};
      last_state = link.state_o;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (link.state_o != st && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(link.state_o), 32'(st));
  endtask

  task automatic dwell(input logic [2:0] st, output int n);
    n = 0;
    while (link.state_o == st && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic drive_all(input logic v);
    link.gtpowergood_i       = {NL{v}};
    link.rxpmaresetdone_i    = {NL{v}};
    link.userclk_rx_active_i = v;
    link.rxbyteisaligned_i   = {NL{v}};
    link.rxchanisaligned_i   = {NL{v}};
  endtask

  task automatic pulse_restart();
    link.restart_i = 1'b1;
    step();
    link.restart_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no summary, expected summary");
    $fatal(1);
  end

  initial begin
    int n, lane, k, phase, fault_left, kind;
    link.restart_i = 1'b0;
    drive_all(1'b0);
    model_reset();
    seq = '0;
    last_state = 3'd0;

    #1 reset_n_i = 1'b0;
    #1;
    compare_outs("reset_state");
    check("reset_all_in_reset", 32'(link.gtwiz_reset_all_o), 32'd1);

    // Bring-up: status rises 10 cycles after release.
    @(negedge clk_i);
    reset_n_i = 1'b1;
    dwell(3'd0, n);
    check("s1_reset_all_width", n, PULSE);
    repeat (2) step();
    drive_all(1'b1);
    wait_state(3'd4, 400, "s1_link_up");
    check("s1_state_order", seq, 32'h0000_1234);

    // Short byte-align glitch survives. A glitch of GLITCH cycles is a loss.
    lane = $urandom_range(0, NL - 1);
    link.rxbyteisaligned_i[lane] = 1'b0;
    repeat (GLITCH - 1) step();
    link.rxbyteisaligned_i[lane] = 1'b1;
    repeat (8) step();
    check("s3_short_glitch_up", 32'(link.link_up_o), 32'd1);
    check("s3_short_glitch_loss", 32'(link.loss_cnt_o), 32'd0);
    lane = $urandom_range(0, NL - 1);
    link.rxbyteisaligned_i[lane] = 1'b0;
    repeat (GLITCH) step();
    link.rxbyteisaligned_i[lane] = 1'b1;
    wait_state(3'd5, 10, "s3_to_reset_dp");
    check("s3_loss", 32'(link.loss_cnt_o), 32'd1);
    wait_state(3'd4, 200, "s3_relink");

    // PLL loss and channel misalignment in the same cycle: the PLL loss wins.
    link.gtpowergood_i[0]     = 1'b0;
    link.rxchanisaligned_i[3] = 1'b0;
    repeat (3) step();
    check("s4_state", 32'(link.state_o), 32'd0);
    check("s4_loss", 32'(link.loss_cnt_o), 32'd2);
    check("s4_retry", 32'(link.retry_cnt_o), 32'd0);
    link.gtpowergood_i[0]     = 1'b1;
    link.rxchanisaligned_i[3] = 1'b1;
    wait_state(3'd4, 300, "s4_relink");

    // Bond flickers every 15 cycles. WAIT_BOND times out exactly at TMO.
    pulse_restart();
    check("s6_restart_state", 32'(link.state_o), 32'd0);
    wait_state(3'd3, 100, "s6_wait_bond");
    lane  = $urandom_range(0, NL - 1);
    phase = $urandom_range(0, 14);
    n = 0;
    while (link.state_o == 3'd3 && n < 400) begin
      link.rxchanisaligned_i[lane] = ((n % 15) != phase);
      n++;
      step();
    end
    link.rxchanisaligned_i[lane] = 1'b1;
    check("s6_bond_dwell", n, TMO);
    check("s6_next_state", 32'(link.state_o), 32'd5);
    check("s6_retry", 32'(link.retry_cnt_o), 32'd1);
    wait_state(3'd4, 300, "s6_relink");

    // A lane that never bonds runs out of retries and the sequencer parks in FAILED.
    pulse_restart();
    lane = $urandom_range(0, NL - 1);
    link.rxchanisaligned_i[lane] = 1'b0;
    wait_state(3'd5, 400, "s2_first_tmo");
    check("s2_retry1", 32'(link.retry_cnt_o), 32'd1);
    dwell(3'd5, n);
    check("s2_rx_dp_width", n, PULSE);
    wait_state(3'd6, 1200, "s2_failed");
    check("s2_fail", 32'(link.fail_o), 32'd1);
    pulse_restart();
    check("s2_restart_state", 32'(link.state_o), 32'd0);
    check("s2_restart_fail", 32'(link.fail_o), 32'd0);
    check("s2_restart_retry", 32'(link.retry_cnt_o), 32'd0);
    link.rxchanisaligned_i[lane] = 1'b1;
    repeat (3) step();
    pulse_restart();
    dwell(3'd0, n);
    check("s2_restart_in_reset_all", n, PULSE);

    // Asynchronous reset in the middle of RESET_DP.
    wait_state(3'd4, 300, "s5_link");
    lane = $urandom_range(0, NL - 1);
    link.rxbyteisaligned_i[lane] = 1'b0;
    repeat (GLITCH) step();
    link.rxbyteisaligned_i[lane] = 1'b1;
    wait_state(3'd5, 10, "s5_reset_dp");
    k = $urandom_range(0, 5);
    repeat (k) step();
    #2 reset_n_i = 1'b0;
    #1;
    model_reset();
    compare_outs("s5_async_reset");
    check("s5_reset_all", 32'(link.gtwiz_reset_all_o), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i  = 1'b1;
    seq        = '0;
    last_state = 3'd0;
    wait_state(3'd4, 300, "s5_relink");
    check("s5_state_order", seq, 32'h0000_1234);

    // Random fault bursts on any status input, plus occasional restarts.
    fault_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (fault_left == 0) begin
        drive_all(1'b1);
        link.restart_i = 1'b0;
        if ($urandom_range(0, 39) == 0) begin
          kind = $urandom_range(0, 5);
          lane = $urandom_range(0, NL - 1);
          fault_left = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 300) : $urandom_range(1, 8);
          case (kind)
            0:       link.gtpowergood_i[lane]     = 1'b0;
            1:       link.rxpmaresetdone_i[lane]  = 1'b0;
            2:       link.userclk_rx_active_i     = 1'b0;
            3:       link.rxbyteisaligned_i[lane] = 1'b0;
            4:       link.rxchanisaligned_i[lane] = 1'b0;
            default: begin link.restart_i = 1'b1; fault_left = 1; end
          endcase
        end
      end else begin
        fault_left--;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
